mac_rgmii_core: RTL and testbench
=================================

MAC_RGMII_CORE -- requirements
Module: mac_rgmii

Interface
REQ-001 phy_rxc  in  1  RGMII receive clock (125 MHz); the only clock; all logic uses its rising edge, and only the RX capture stage (REQ-012) also uses its falling edge.
REQ-002 rst_n  in  1  reset, synchronous and active-low.
REQ-003 phy_rxd  in  4  RGMII receive data, DDR.
REQ-004 phy_rx_ctl  in  1  RGMII RX_CTL; RX_DV on the rising edge, RX_DV xor RX_ER on the falling edge.
REQ-005 mac_rx_data_o  out  8  received frame byte.
REQ-006 mac_rx_valid_o  out  1  mac_rx_data_o valid this cycle.
REQ-007 mac_rx_sof_o / mac_rx_eof_o  out  1 each  first / last byte of a frame, qualified by valid.
REQ-008 mac_rx_clk_o  out  1  equals phy_rxc; all mac_rx_* outputs are synchronous to it.
REQ-009 eth_status_o  out  8  status: [0] link, [2:1] speed, [3] duplex, [4] last frame FCS good, [5] last frame FCS bad, [6] RX_ER seen (sticky), [7] frame in progress.
REQ-010 mac_tx_data in 8; mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_clk, mac_tx_clk_90 in 1 each; the transmit byte interface and clocks, where sof, eof, mac_tx_clk and mac_tx_clk_90 are accepted and ignored.
REQ-011 phy_txd out 4; phy_tx_ctl out 1; phy_txc out 1; RGMII transmit outputs.

Function
REQ-012 Each rising edge SHALL capture the low nibble and RX_DV; the following falling edge SHALL capture the high nibble and RX_DV^RX_ER; the assembled byte is used on the next rising edge.
REQ-013 When RX_DV=0 and RX_ER=0 and both nibbles of a byte are equal, eth_status_o[3:0] SHALL load that nibble (in-band status); otherwise it holds.
REQ-014 The RX state machine SHALL have four states. IDLE goes to PREAMBLE when RX_DV=1. In PREAMBLE, a byte 0x55 stays, 0xD5 goes to DATA, and any other byte goes to DROP. DATA and DROP return to IDLE when RX_DV=0.
REQ-015 Preamble and SFD SHALL NOT be output; every byte received in DATA, FCS included, SHALL be output in order.
REQ-016 Output SHALL lag byte assembly by one byte-stage.
REQ-017 sof SHALL mark the first DATA byte; eof SHALL mark the byte after which RX_DV falls. A 1-byte frame SHALL assert sof and eof together.
REQ-018 valid SHALL be low outside DATA output. Frames ended in PREAMBLE or DROP SHALL produce no output and no status update.
REQ-019 FCS check: compute IEEE 802.3 CRC-32 (reflected, poly 0xEDB88320, init 0xFFFFFFFF) over DA through FCS.
REQ-020 At eof, set [4]=1,[5]=0 if the register equals 0xDEBB20E3, else [4]=0,[5]=1.
REQ-021 RX_ER=1 during DATA SHALL force [5]=1 at eof and set [6]; [6] clears only on reset.
REQ-022 [7]=1 from SFD detection until the eof cycle.
REQ-023 TX: on each rising edge, register mac_tx_data and mac_tx_valid.
REQ-024 phy_txd SHALL present the registered data low nibble while phy_rxc is high and the high nibble while it is low; phy_tx_ctl SHALL equal registered valid on both halves (TX_ER=0).
REQ-025 phy_txc SHALL equal phy_rxc. No preamble or FCS is inserted; the user supplies complete wire bytes.
REQ-026 Back-to-back frames with ≥1 idle byte SHALL be handled without loss.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE; mac_rx_data_o=0, valid/sof/eof=0; eth_status_o=0x00; phy_txd=0; phy_tx_ctl=0; CRC register=0xFFFFFFFF.
REQ-028 Reset mid-frame SHALL abort the frame with no eof; after reset release, the module SHALL wait for RX_DV=0 before accepting a new frame.

Verification
REQ-029 Idle, RX_DV=0, rxd=0xD for 4 cycles -> eth_status_o[3:0]=0xD (link up, 1000M, full duplex).
REQ-030 Preamble 7x55 + D5 + 60-byte ARP (DA FF..FF, SA E0:91:F5:B4:06:B0, type 0806) + correct FCS -> 64 valid bytes; sof with first 0xFF; eof with last FCS byte; status [4]=1, [5]=0.
REQ-031 Same frame with one payload byte flipped -> 64 bytes output; [4]=0, [5]=1.
REQ-032 Preamble containing 0x12 before D5 -> no valid, eth_status_o[5:4] unchanged.
REQ-033 RX_ER pulse mid-frame -> [5]=1 and [6]=1 at eof.
REQ-034 mac_tx_valid=1, mac_tx_data=0xA5 for one cycle -> next cycle phy_txd=5 while phy_rxc is high, A while it is low, phy_tx_ctl=1; then phy_tx_ctl=0.

Source files
------------

// File: rtl/mac_rgmii_core.sv
// RGMII MAC core: DDR receive capture, preamble/SFD framing with CRC-32 check
// and in-band status, plus a pass-through DDR transmit path.
module mac_rgmii_core (
    input  logic       phy_rxc,
    input  logic       rst_n,
    input  logic [3:0] phy_rxd,
    input  logic       phy_rx_ctl,
    output logic [7:0] mac_rx_data_o,
    output logic       mac_rx_valid_o,
    output logic       mac_rx_sof_o,
    output logic       mac_rx_eof_o,
    output logic       mac_rx_clk_o,
    output logic [7:0] eth_status_o,
    input  logic [7:0] mac_tx_data,
    input  logic       mac_tx_valid,
    input  logic       mac_tx_sof,
    input  logic       mac_tx_eof,
    input  logic       mac_tx_clk,
    input  logic       mac_tx_clk_90,
    output logic [3:0] phy_txd,
    output logic       phy_tx_ctl,
    output logic       phy_txc
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CRC_W  = 32;

    localparam logic [CRC_W-1:0]  CRC_POLY    = 32'hEDB8_8320;
    localparam logic [CRC_W-1:0]  CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0]  CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [BYTE_W-1:0] PRE_BYTE    = 8'h55;
    localparam logic [BYTE_W-1:0] SFD_BYTE    = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_t;

    state_t state, state_nxt;

    logic [NIB_W-1:0]  rx_lo, rx_hi;
    logic              rx_dv, rx_dvx;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_dv, byte_er;

    logic              armed;
    logic              pend_vld, pend_sof;
    logic [BYTE_W-1:0] pend_data;
    logic [CRC_W-1:0]  crc;
    logic              frame_er;
    logic              sfd_hit, data_hit, eof_hit;

    logic [BYTE_W-1:0] tx_data_r;
    logic              tx_vld_r;
    logic              unused_tx;

    function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c,
                                                  input logic [BYTE_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    // Rising half: low nibble and RX_DV. Reset reads as "busy" so a release
    // in the middle of a frame cannot arm the receiver early.
    always_ff @(posedge phy_rxc) begin
        if (!rst_n) begin
            rx_lo <= '0;
            rx_dv <= 1'b1;
        end else begin
            rx_lo <= phy_rxd;
            rx_dv <= phy_rx_ctl;
        end
    end

    // Falling half: high nibble and RX_DV^RX_ER
    always_ff @(negedge phy_rxc) begin
        rx_hi  <= phy_rxd;
        rx_dvx <= phy_rx_ctl;
    end

    assign byte_data = {rx_hi, rx_lo};
    assign byte_dv   = rx_dv;
    assign byte_er   = rx_dv ^ rx_dvx;
    assign eof_hit   = pend_vld && !byte_dv;

    always_ff @(posedge phy_rxc) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sfd_hit   = 1'b0;
        data_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (byte_dv && armed) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!byte_dv) begin
                    state_nxt = ST_IDLE;
                end else if (byte_data == SFD_BYTE) begin
                    state_nxt = ST_DATA;
                    sfd_hit   = 1'b1;
                end else if (byte_data != PRE_BYTE) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!byte_dv) state_nxt = ST_IDLE;
                else          data_hit  = 1'b1;
            end
            ST_DROP: begin
                if (!byte_dv) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One-byte holding stage: eof is only known once the next byte shows RX_DV low
    always_ff @(posedge phy_rxc) begin
        if (!rst_n) begin
            armed          <= 1'b0;
            pend_vld       <= 1'b0;
            pend_sof       <= 1'b0;
            pend_data      <= '0;
            crc            <= CRC_INIT;
            frame_er       <= 1'b0;
            mac_rx_data_o  <= '0;
            mac_rx_valid_o <= 1'b0;
            mac_rx_sof_o   <= 1'b0;
            mac_rx_eof_o   <= 1'b0;
            eth_status_o   <= '0;
        end else begin
            if (!byte_dv) armed <= 1'b1;

            pend_vld <= data_hit;
            if (data_hit) begin
                pend_data <= byte_data;
                pend_sof  <= !pend_vld;
            end

            mac_rx_valid_o <= pend_vld;
            mac_rx_data_o  <= pend_vld ? pend_data : '0;
            mac_rx_sof_o   <= pend_vld && pend_sof;
            mac_rx_eof_o   <= eof_hit;

            if (sfd_hit)       crc <= CRC_INIT;
            else if (data_hit) crc <= crc_next(crc, byte_data);

            if (sfd_hit)                  frame_er <= 1'b0;
            else if (data_hit && byte_er) frame_er <= 1'b1;

            if (!byte_dv && !byte_er && (rx_hi == rx_lo)) eth_status_o[3:0] <= rx_lo;

            if (eof_hit) begin
                eth_status_o[4] <= (crc == CRC_RESIDUE) && !frame_er;
                eth_status_o[5] <= !((crc == CRC_RESIDUE) && !frame_er);
            end

            if (data_hit && byte_er) eth_status_o[6] <= 1'b1;

            if (sfd_hit)                              eth_status_o[7] <= 1'b1;
            else if ((state == ST_DATA) && !byte_dv)  eth_status_o[7] <= 1'b0;
        end
    end

    // Transmit: one register stage, nibbles muxed on the receive clock phase
    always_ff @(posedge phy_rxc) begin
        if (!rst_n) begin
            tx_data_r <= '0;
            tx_vld_r  <= 1'b0;
        end else begin
            tx_data_r <= mac_tx_data;
            tx_vld_r  <= mac_tx_valid;
        end
    end

    assign phy_txd      = phy_rxc ? tx_data_r[3:0] : tx_data_r[7:4];
    assign phy_tx_ctl   = tx_vld_r;
    assign phy_txc      = phy_rxc;
    assign mac_rx_clk_o = phy_rxc;

    assign unused_tx = ^{mac_tx_sof, mac_tx_eof, mac_tx_clk, mac_tx_clk_90};

endmodule

// File: tb/tb_mac_rgmii_core.sv
// Directed bench for mac_rgmii_core: in-band status, framing, FCS check,
// RX_ER handling, mid-frame reset and the DDR transmit path.
module tb_mac_rgmii_core;

    logic       phy_rxc = 1'b0;
    logic       rst_n;
    logic [3:0] phy_rxd;
    logic       phy_rx_ctl;
    logic [7:0] mac_rx_data_o;
    logic       mac_rx_valid_o, mac_rx_sof_o, mac_rx_eof_o, mac_rx_clk_o;
    logic [7:0] eth_status_o;
    logic [7:0] mac_tx_data;
    logic       mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_clk, mac_tx_clk_90;
    logic [3:0] phy_txd;
    logic       phy_tx_ctl, phy_txc;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] frm [0:63];
    logic [7:0] rx_q [$];
    int         sof_cnt, eof_cnt, sof_idx, eof_idx;
    logic       st7_at_sof;

    mac_rgmii_core dut (
        .phy_rxc        (phy_rxc),
        .rst_n          (rst_n),
        .phy_rxd        (phy_rxd),
        .phy_rx_ctl     (phy_rx_ctl),
        .mac_rx_data_o  (mac_rx_data_o),
        .mac_rx_valid_o (mac_rx_valid_o),
        .mac_rx_sof_o   (mac_rx_sof_o),
        .mac_rx_eof_o   (mac_rx_eof_o),
        .mac_rx_clk_o   (mac_rx_clk_o),
        .eth_status_o   (eth_status_o),
        .mac_tx_data    (mac_tx_data),
        .mac_tx_valid   (mac_tx_valid),
        .mac_tx_sof     (mac_tx_sof),
        .mac_tx_eof     (mac_tx_eof),
        .mac_tx_clk     (mac_tx_clk),
        .mac_tx_clk_90  (mac_tx_clk_90),
        .phy_txd        (phy_txd),
        .phy_tx_ctl     (phy_tx_ctl),
        .phy_txc        (phy_txc)
    );

    always #4 phy_rxc = ~phy_rxc;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1);
    end

    // Collect received bytes away from the active edge
    always @(negedge phy_rxc) begin
        if (rst_n === 1'b1 && mac_rx_valid_o === 1'b1) begin
            rx_q.push_back(mac_rx_data_o);
            if (mac_rx_sof_o === 1'b1) begin
                sof_cnt++;
                sof_idx    = rx_q.size() - 1;
                st7_at_sof = eth_status_o[7];
            end
            if (mac_rx_eof_o === 1'b1) begin
                eof_cnt++;
                eof_idx = rx_q.size() - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc32_upd(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ d[j];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    // 60-byte ARP request followed by its FCS, least significant byte first
    task automatic build_arp();
        logic [7:0]  hdr [0:41];
        logic [31:0] c;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'hE0, 8'h91, 8'hF5, 8'hB4, 8'h06, 8'hB0,
                8'h08, 8'h06,
                8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                8'hE0, 8'h91, 8'hF5, 8'hB4, 8'h06, 8'hB0,
                8'hC0, 8'hA8, 8'h01, 8'h64,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hC0, 8'hA8, 8'h01, 8'h01};
        for (int i = 0; i < 60; i++) frm[i] = (i < 42) ? hdr[i] : 8'h00;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) c = crc32_upd(c, frm[i]);
        c = ~c;
        frm[60] = c[7:0];
        frm[61] = c[15:8];
        frm[62] = c[23:16];
        frm[63] = c[31:24];
    endtask

    // Called between a falling edge and the next rising edge
    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
        phy_rxd    = b[3:0];
        phy_rx_ctl = dv;
        @(posedge phy_rxc); #1;
        phy_rxd    = b[7:4];
        phy_rx_ctl = dv ^ er;
        @(negedge phy_rxc); #1;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hDD, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input int er_idx, input logic bad_pre);
        for (int i = 0; i < 7; i++) send_byte((bad_pre && i == 3) ? 8'h12 : 8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) send_byte(frm[i], 1'b1, i == er_idx);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        sof_cnt    = 0;
        eof_cnt    = 0;
        sof_idx    = -1;
        eof_idx    = -1;
        st7_at_sof = 1'b0;
    endtask

    function automatic int count_mismatch(input int n);
        int m = 0;
        for (int i = 0; i < n; i++)
            if (i >= rx_q.size() || rx_q[i] !== frm[i]) m++;
        return m;
    endfunction

    initial begin
        rst_n         = 1'b0;
        phy_rxd       = 4'h0;
        phy_rx_ctl    = 1'b0;
        mac_tx_data   = 8'h00;
        mac_tx_valid  = 1'b0;
        mac_tx_sof    = 1'b0;
        mac_tx_eof    = 1'b0;
        mac_tx_clk    = 1'b0;
        mac_tx_clk_90 = 1'b0;
        clear_mon();

        // Reset values
        repeat (4) @(negedge phy_rxc);
        #1;
        chk("rst_status", 32'(eth_status_o), 32'h00);
        chk("rst_valid", 32'(mac_rx_valid_o), 32'h0);
        chk("rst_sof_eof", 32'({mac_rx_sof_o, mac_rx_eof_o}), 32'h0);
        chk("rst_data", 32'(mac_rx_data_o), 32'h00);
        chk("rst_txd_low_phase", 32'(phy_txd), 32'h0);
        chk("rst_tx_ctl", 32'(phy_tx_ctl), 32'h0);
        chk("rx_clk_low", 32'({mac_rx_clk_o, phy_txc}), 32'h0);
        @(posedge phy_rxc); #1;
        chk("rst_txd_high_phase", 32'(phy_txd), 32'h0);
        chk("rx_clk_high", 32'({mac_rx_clk_o, phy_txc}), 32'h3);
        @(negedge phy_rxc); #1;
        rst_n = 1'b1;

        // In-band status: link up, 1000M, full duplex
        send_idle(4);
        chk("inband_status", 32'(eth_status_o), 32'h0D);

        // Good ARP frame
        build_arp();
        clear_mon();
        send_frame(64, -1, 1'b0);
        send_idle(4);
        chk("good_len", 32'(rx_q.size()), 32'd64);
        chk("good_first", 32'(rx_q[0]), 32'hFF);
        chk("good_sof", 32'({sof_cnt[7:0], sof_idx[7:0]}), 32'h0100);
        chk("good_eof", 32'({eof_cnt[7:0], eof_idx[7:0]}), 32'h013F);
        chk("good_last_fcs", 32'(rx_q[63]), 32'(frm[63]));
        chk("good_bytes_bad", 32'(count_mismatch(64)), 32'd0);
        chk("good_inprog_at_sof", 32'(st7_at_sof), 32'h1);
        chk("good_status", 32'(eth_status_o), 32'h1D);

        // Same frame, one payload byte flipped
        frm[20] = frm[20] ^ 8'h01;
        clear_mon();
        send_frame(64, -1, 1'b0);
        send_idle(4);
        chk("badfcs_len", 32'(rx_q.size()), 32'd64);
        chk("badfcs_bytes_bad", 32'(count_mismatch(64)), 32'd0);
        chk("badfcs_status", 32'(eth_status_o), 32'h2D);

        // Corrupt preamble: frame dropped, FCS status untouched
        build_arp();
        clear_mon();
        send_frame(64, -1, 1'b1);
        send_idle(4);
        chk("badpre_len", 32'(rx_q.size()), 32'd0);
        chk("badpre_status", 32'(eth_status_o), 32'h2D);

        // RX_ER mid-frame on an otherwise good frame
        clear_mon();
        send_frame(64, 30, 1'b0);
        send_idle(4);
        chk("rxer_len", 32'(rx_q.size()), 32'd64);
        chk("rxer_eof_cnt", 32'(eof_cnt), 32'd1);
        chk("rxer_status", 32'(eth_status_o), 32'h6D);

        // Single-byte frame
        frm[0] = 8'h3C;
        clear_mon();
        send_frame(1, -1, 1'b0);
        send_idle(4);
        chk("one_len", 32'(rx_q.size()), 32'd1);
        chk("one_data", 32'(rx_q[0]), 32'h3C);
        chk("one_sof_eof", 32'({sof_cnt[3:0], eof_cnt[3:0], sof_idx[3:0], eof_idx[3:0]}), 32'h1100);

        // Back-to-back good frames, single idle byte between
        build_arp();
        clear_mon();
        send_frame(64, -1, 1'b0);
        send_idle(1);
        send_frame(64, -1, 1'b0);
        send_idle(4);
        chk("b2b_len", 32'(rx_q.size()), 32'd128);
        chk("b2b_sof_eof_cnt", 32'({sof_cnt[7:0], eof_cnt[7:0]}), 32'h0202);
        chk("b2b_status", 32'(eth_status_o), 32'h5D);

        // Reset in the middle of a frame
        clear_mon();
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(frm[i], 1'b1, 1'b0);
        rst_n = 1'b0;
        clear_mon();
        send_byte(frm[10], 1'b1, 1'b0);
        send_byte(frm[11], 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 12; i < 64; i++) send_byte(frm[i], 1'b1, 1'b0);
        send_idle(4);
        chk("midrst_len", 32'(rx_q.size()), 32'd0);
        chk("midrst_eof_cnt", 32'(eof_cnt), 32'd0);
        chk("midrst_status", 32'(eth_status_o), 32'h0D);
        clear_mon();
        send_frame(64, -1, 1'b0);
        send_idle(4);
        chk("postrst_len", 32'(rx_q.size()), 32'd64);
        chk("postrst_status", 32'(eth_status_o), 32'h1D);

        // Transmit: 0xA5 for one cycle
        mac_tx_valid = 1'b1;
        mac_tx_data  = 8'hA5;
        @(posedge phy_rxc); #1;
        mac_tx_valid = 1'b0;
        mac_tx_data  = 8'h00;
        #1;
        chk("tx_low_nibble", 32'(phy_txd), 32'h5);
        chk("tx_ctl_high_phase", 32'(phy_tx_ctl), 32'h1);
        @(negedge phy_rxc); #1;
        chk("tx_high_nibble", 32'(phy_txd), 32'hA);
        chk("tx_ctl_low_phase", 32'(phy_tx_ctl), 32'h1);
        @(posedge phy_rxc); #1;
        chk("tx_ctl_after", 32'(phy_tx_ctl), 32'h0);
        chk("tx_txd_after", 32'(phy_txd), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
